// File: rtl/regfile_sb_pkg.sv
// Shared types and helpers for the bexkat1 register file family.
// ext() and phys_addr() are width-agnostic; callers cast results to their own widths.
package bexkat1_pkg;

    typedef enum logic [1:0] {
        SZ_WORD0 = 2'd0,
        SZ_BYTE  = 2'd1,
        SZ_HALF  = 2'd2,
        SZ_WORD  = 2'd3
    } size_t;

    // Works on a 64-bit carrier so any register width up to 64 can share it.
    function automatic logic [63:0] ext(input size_t size, input logic sgn, input logic [63:0] d);
        logic [63:0] r;
        case (size)
            SZ_BYTE: r = {{56{sgn & d[7]}}, d[7:0]};
            SZ_HALF: r = {{48{sgn & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // The supervisor stack pointer lives in the extra entry just past the architectural file.
    function automatic int phys_addr(input int a, input int spreg, input logic sup, input int count);
        return (sup && (a == spreg)) ? count : a;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/writeback logic (master) and the register file (slave).
interface regfile_sb_if #(
    parameter int WIDTH  = 32,
    parameter int COUNTP = 4,
    parameter int NREAD  = 3
);
    import bexkat1_pkg::*;

    logic                      supervisor;
    logic [NREAD*COUNTP-1:0]   rd_addr;
    logic [NREAD*WIDTH-1:0]    rd_data;
    logic [NREAD-1:0]          rd_busy;
    logic                      wr_en;
    logic [COUNTP-1:0]         wr_addr;
    logic [WIDTH-1:0]          wr_data;
    size_t                     wr_size;
    logic                      wr_signed;
    logic                      sp_en;
    size_t                     sp_size;
    logic [WIDTH-1:0]          sp_data_i;
    logic [WIDTH-1:0]          sp_data_o;
    logic                      rsv_en;
    logic [COUNTP-1:0]         rsv_addr;
    logic                      busy_any;

    modport master (
        output supervisor, rd_addr, wr_en, wr_addr, wr_data, wr_size, wr_signed,
               sp_en, sp_size, sp_data_i, rsv_en, rsv_addr,
        input  rd_data, rd_busy, sp_data_o, busy_any
    );

    modport slave (
        input  supervisor, rd_addr, wr_en, wr_addr, wr_data, wr_size, wr_signed,
               sp_en, sp_size, sp_data_i, rsv_en, rsv_addr,
        output rd_data, rd_busy, sp_data_o, busy_any
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write tracker: one busy bit per physical entry, indexed by physical address only.
module regfile_scoreboard #(
    parameter int COUNTP = 4,
    parameter int NREAD  = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rsv_en,
    input  logic [COUNTP:0]             rsv_p,
    input  logic                        wr_en,
    input  logic [COUNTP:0]             wr_p,
    input  logic                        sp_en,
    input  logic [COUNTP:0]             sp_p,
    input  logic [NREAD*(COUNTP+1)-1:0] rd_p,
    output logic [NREAD-1:0]            rd_busy,
    output logic                        busy_any
);
    localparam int COUNT = 2 ** COUNTP;
    localparam int PW    = COUNTP + 1;

    logic [COUNT:0] r_busy;
    logic [COUNT:0] w_busy_next;
    logic [COUNT:0] w_written;

    // A same-cycle reserve wins over the write: it belongs to a later writeback.
    for (genvar gi = 0; gi <= COUNT; gi++) begin : g_entry
        assign w_written[gi]   = (wr_en && (wr_p == PW'(gi))) || (sp_en && (sp_p == PW'(gi)));
        assign w_busy_next[gi] = (rsv_en && (rsv_p == PW'(gi))) | (r_busy[gi] & ~w_written[gi]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
        logic [PW-1:0] w_p;
        assign w_p         = rd_p[gi*PW +: PW];
        assign rd_busy[gi] = r_busy[w_p] & ~w_written[w_p];
    end

    assign busy_any = |r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Banked-SP register file with sized writes, full same-cycle read bypass and a
// write-pending scoreboard. Supports WIDTH from 16 to 64 in multiples of 8.
module regfile_sb
    import bexkat1_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int COUNTP = 4,
    parameter int SPREG  = 15,
    parameter int NREAD  = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    regfile_sb_if.slave  bus
);
    localparam int COUNT = 2 ** COUNTP;
    localparam int PW    = COUNTP + 1;

    logic [WIDTH-1:0]      r_regs [0:COUNT];

    logic [PW-1:0]         w_wr_p;
    logic [PW-1:0]         w_sp_p;
    logic [PW-1:0]         w_rsv_p;
    logic [WIDTH-1:0]      w_wr_val;
    logic [WIDTH-1:0]      w_sp_val;
    logic                  w_wr_eff;
    logic [NREAD*PW-1:0]   w_rd_p;

    assign w_wr_p  = PW'(phys_addr(32'(bus.wr_addr), SPREG, bus.supervisor, COUNT));
    assign w_sp_p  = PW'(phys_addr(SPREG, SPREG, bus.supervisor, COUNT));
    assign w_rsv_p = PW'(phys_addr(32'(bus.rsv_addr), SPREG, bus.supervisor, COUNT));

    assign w_wr_val = WIDTH'(ext(bus.wr_size, bus.wr_signed, 64'(bus.wr_data)));
    assign w_sp_val = WIDTH'(ext(bus.sp_size, 1'b0, 64'(bus.sp_data_i)));

    // The SP port owns its entry outright when both ports collide.
    assign w_wr_eff = bus.wr_en && !(bus.sp_en && (w_wr_p == w_sp_p));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j <= COUNT; j++) begin
                r_regs[j] <= '0;
            end
        end else begin
            if (w_wr_eff) begin
                r_regs[w_wr_p] <= w_wr_val;
            end
            if (bus.sp_en) begin
                r_regs[w_sp_p] <= w_sp_val;
            end
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
        logic [PW-1:0] w_p;
        assign w_p = PW'(phys_addr(32'(bus.rd_addr[gi*COUNTP +: COUNTP]), SPREG, bus.supervisor, COUNT));
        assign w_rd_p[gi*PW +: PW] = w_p;
        assign bus.rd_data[gi*WIDTH +: WIDTH] =
            (bus.sp_en && (w_sp_p == w_p)) ? w_sp_val :
            (w_wr_eff  && (w_wr_p == w_p)) ? w_wr_val :
                                             r_regs[w_p];
    end

    assign bus.sp_data_o = bus.sp_en                        ? w_sp_val :
                           (w_wr_eff && (w_wr_p == w_sp_p)) ? w_wr_val :
                                                              r_regs[w_sp_p];

    regfile_scoreboard #(
        .COUNTP (COUNTP),
        .NREAD  (NREAD)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rsv_en   (bus.rsv_en),
        .rsv_p    (w_rsv_p),
        .wr_en    (w_wr_eff),
        .wr_p     (w_wr_p),
        .sp_en    (bus.sp_en),
        .sp_p     (w_sp_p),
        .rd_p     (w_rd_p),
        .rd_busy  (bus.rd_busy),
        .busy_any (bus.busy_any)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected values queued at drive time, popped at sample time.
module tb_regfile_sb;
    import bexkat1_pkg::*;

    localparam int WIDTH  = 32;
    localparam int COUNTP = 4;
    localparam int NREAD  = 3;
    localparam int SPREG  = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.WIDTH(WIDTH), .COUNTP(COUNTP), .NREAD(NREAD)) bus ();

    regfile_sb #(
        .WIDTH  (WIDTH),
        .COUNTP (COUNTP),
        .SPREG  (SPREG),
        .NREAD  (NREAD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        $display("check %-12s observed=%h expected=%h", tag, obs, e);
    endtask

    function automatic logic [31:0] rdp(input int i);
        return bus.rd_data[i*WIDTH +: WIDTH];
    endfunction

    task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        bus.rd_addr = {a2, a1, a0};
    endtask

    task automatic idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_size   = SZ_WORD;
        bus.wr_signed = 1'b0;
        bus.sp_en     = 1'b0;
        bus.sp_size   = SZ_WORD;
        bus.sp_data_i = '0;
        bus.rsv_en    = 1'b0;
        bus.rsv_addr  = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input size_t sz, input logic sg);
        bus.wr_en     = 1'b1;
        bus.wr_addr   = a;
        bus.wr_data   = d;
        bus.wr_size   = sz;
        bus.wr_signed = sg;
    endtask

    task automatic spw(input logic [31:0] d, input size_t sz);
        bus.sp_en     = 1'b1;
        bus.sp_data_i = d;
        bus.sp_size   = sz;
    endtask

    task automatic rsv(input logic [3:0] a);
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.supervisor = 1'b0;
        set_rd(0, 15, 3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        chk("rst_rd0", rdp(0)); chk("rst_rd1", rdp(1)); chk("rst_rd2", rdp(2));
        chk("rst_sp", bus.sp_data_o); chk("rst_busyany", 32'(bus.busy_any));
        chk("rst_rdbusy", 32'(bus.rd_busy));

        // Signed byte write, bypass then storage
        tick(); wr(3, 32'h12345680, SZ_BYTE, 1'b1); set_rd(3, 15, 4);
        exp_q.push_back(32'hFFFFFF80);
        @(negedge clk); chk("byte_byp", rdp(0));
        tick(); idle(); wr(4, 32'hABCD8765, SZ_HALF, 1'b0);
        exp_q.push_back(32'hFFFFFF80); exp_q.push_back(32'h00008765);
        @(negedge clk); chk("byte_store", rdp(0)); chk("half_zext", rdp(2));
        tick(); idle(); wr(4, 32'hABCD8765, SZ_HALF, 1'b1);
        exp_q.push_back(32'hFFFF8765);
        @(negedge clk); chk("half_sext", rdp(2));
        tick(); idle(); wr(6, 32'hDEADBEEF, SZ_WORD0, 1'b1); set_rd(6, 15, 4);
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk); chk("word0_byp", rdp(0));
        tick(); idle();
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hFFFF8765);
        @(negedge clk); chk("word0_store", rdp(0)); chk("half_store", rdp(2));

        // SP banking
        tick(); bus.supervisor = 1'b0; spw(32'h1000, SZ_WORD);
        exp_q.push_back(32'h1000);
        @(negedge clk); chk("usp_byp", bus.sp_data_o);
        tick(); bus.supervisor = 1'b1; spw(32'h2000, SZ_WORD);
        exp_q.push_back(32'h2000);
        @(negedge clk); chk("ssp_byp", bus.sp_data_o);
        tick(); idle(); set_rd(15, 15, 0);
        exp_q.push_back(32'h2000); exp_q.push_back(32'h2000);
        @(negedge clk); chk("ssp_rd", rdp(0)); chk("ssp_out", bus.sp_data_o);
        tick(); bus.supervisor = 1'b0;
        exp_q.push_back(32'h1000); exp_q.push_back(32'h1000);
        @(negedge clk); chk("usp_rd", rdp(0)); chk("usp_out", bus.sp_data_o);
        tick(); bus.supervisor = 1'b1; spw(32'h12345681, SZ_BYTE);
        exp_q.push_back(32'h00000081);
        @(negedge clk); chk("sp_byte_zx", bus.sp_data_o);

        // Write collision on user SP
        tick(); idle(); bus.supervisor = 1'b0; set_rd(15, 15, 15);
        wr(15, 32'hAAAA, SZ_WORD, 1'b0); spw(32'hBBBB, SZ_WORD);
        exp_q.push_back(32'hBBBB); exp_q.push_back(32'hBBBB);
        exp_q.push_back(32'hBBBB); exp_q.push_back(32'hBBBB);
        @(negedge clk);
        chk("col_rd0", rdp(0)); chk("col_rd1", rdp(1)); chk("col_rd2", rdp(2));
        chk("col_sp", bus.sp_data_o);
        tick(); idle();
        exp_q.push_back(32'hBBBB); exp_q.push_back(32'hBBBB);
        @(negedge clk); chk("col_store", rdp(0)); chk("col_sp_st", bus.sp_data_o);
        tick(); bus.supervisor = 1'b1;
        exp_q.push_back(32'h00000081);
        @(negedge clk); chk("ssp_intact", rdp(0));

        // Scoreboard basic
        tick(); idle(); bus.supervisor = 1'b0; set_rd(0, 0, 5); rsv(5);
        exp_q.push_back(32'h0);
        @(negedge clk); chk("rsv_same", 32'(bus.rd_busy));
        tick(); idle();
        exp_q.push_back(32'h4); exp_q.push_back(32'h1);
        @(negedge clk); chk("rsv_busy", 32'(bus.rd_busy)); chk("rsv_any", 32'(bus.busy_any));
        tick(); wr(5, 32'h55, SZ_WORD, 1'b0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h55); exp_q.push_back(32'h1);
        @(negedge clk);
        chk("wb_busy", 32'(bus.rd_busy)); chk("wb_data", rdp(2)); chk("wb_any", 32'(bus.busy_any));
        tick(); idle();
        exp_q.push_back(32'h0);
        @(negedge clk); chk("wb_clr_any", 32'(bus.busy_any));

        // Reserve and write the same entry
        tick(); set_rd(7, 0, 0); rsv(7); wr(7, 32'h77, SZ_WORD, 1'b0);
        exp_q.push_back(32'h0);
        @(negedge clk); chk("rw7_same", 32'(bus.rd_busy));
        tick(); idle();
        exp_q.push_back(32'h1); exp_q.push_back(32'h77);
        @(negedge clk); chk("rw7_busy", 32'(bus.rd_busy)); chk("rw7_data", rdp(0));
        tick(); wr(7, 32'h78, SZ_WORD, 1'b0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h78);
        @(negedge clk); chk("rw7_wb", 32'(bus.rd_busy)); chk("rw7_wbdata", rdp(0));
        tick(); idle();
        exp_q.push_back(32'h0);
        @(negedge clk); chk("rw7_any", 32'(bus.busy_any));

        // Reservation made in supervisor mode stays on the supervisor SP
        tick(); bus.supervisor = 1'b1; set_rd(15, 0, 0); rsv(15);
        tick(); idle();
        exp_q.push_back(32'h1);
        @(negedge clk); chk("ssp_busy", 32'(bus.rd_busy));
        tick(); bus.supervisor = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        @(negedge clk); chk("usp_notbusy", 32'(bus.rd_busy)); chk("ssp_any", 32'(bus.busy_any));
        tick(); bus.supervisor = 1'b1; spw(32'h3000, SZ_WORD);
        exp_q.push_back(32'h0); exp_q.push_back(32'h3000);
        @(negedge clk); chk("ssp_wb", 32'(bus.rd_busy)); chk("ssp_wbdata", rdp(0));
        tick(); idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h3000);
        @(negedge clk); chk("ssp_clr", 32'(bus.busy_any)); chk("ssp_store", rdp(0));

        // Reset mid-operation
        tick(); bus.supervisor = 1'b0; rsv(2);
        tick(); idle(); rsv(9);
        tick(); idle(); set_rd(9, 2, 0); rst = 1'b1; wr(9, 32'h99, SZ_WORD, 1'b0);
        exp_q.push_back(32'h2); exp_q.push_back(32'h1);
        @(negedge clk); chk("pre_rst_bsy", 32'(bus.rd_busy)); chk("pre_rst_any", 32'(bus.busy_any));
        tick(); idle(); rst = 1'b0; set_rd(9, 2, 3);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        chk("rst_e9", rdp(0)); chk("rst_e3", rdp(2));
        chk("rst_bsy", 32'(bus.rd_busy)); chk("rst_any", 32'(bus.busy_any));

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the bexkat1 register file. Provides NREAD forwarded read ports and two write ports: a general write-back port and a dedicated stack-pointer port. The stack pointer is banked into user and supervisor copies. Writes carry byte/halfword/word sizing with optional sign extension. An integrated scoreboard tracks registers with an in-flight write, so the decode stage can stall on read-after-write hazards without keeping its own bookkeeping.

## Interface
Parameters:
- WIDTH, 32, register width; must be ≥16 and a multiple of 8
- COUNTP, 4, architectural register address bits; COUNT = 2**COUNTP
- SPREG, 15, architectural index of the stack pointer
- NREAD, 3, number of read ports

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- supervisor  in  1  selects supervisor SP bank for every SPREG access
- rd_addr  in  NREAD*COUNTP  packed read addresses; port i uses slice i
- rd_data  out  NREAD*WIDTH  packed read data, forwarded
- rd_busy  out  NREAD  port i's register has a pending write
- wr_en  in  1  general write strobe
- wr_addr  in  COUNTP  general write address
- wr_data  in  WIDTH  general write data
- wr_size  in  2  0=word, 1=byte, 2=half, 3=word
- wr_signed  in  1  sign-extend byte/half instead of zero-extend
- sp_en  in  1  SP port write strobe
- sp_size  in  2  same encoding as wr_size; always zero-extended
- sp_data_i  in  WIDTH  SP port write data
- sp_data_o  out  WIDTH  current banked SP, forwarded
- rsv_en  in  1  reserve: mark rsv_addr as having a write in flight
- rsv_addr  in  COUNTP  register to reserve
- busy_any  out  1  OR of all busy bits

## Operation
- **Physical storage.** COUNT+1 entries. Index p(a) = a, except when a==SPREG && supervisor, where p = COUNT (supervisor SP). User SP is entry SPREG. Every port resolves addresses through p(), using the current-cycle supervisor.
- **Extension.** ext(size, signed, d):
  - byte keeps d[7:0]
  - half keeps d[15:0]
  - word keeps all bits
  - upper bits are zero, or copies of the kept MSB when signed.
- **General write.** When wr_en, entry p(wr_addr) gets ext(wr_size, wr_signed, wr_data) at the clock edge.
- **SP write.** When sp_en, entry p(SPREG) gets ext(sp_size, 0, sp_data_i).
- **Write collision.** If both writes resolve to the same entry in one cycle, the SP port wins and the general write is dropped.
- **Reads.** rd_data[i] = entry p(rd_addr[i]) with same-cycle bypass: the SP-port value if it targets that entry, else the general-write value if it targets that entry, else storage. sp_data_o uses the same bypass for p(SPREG). Bypassed values are already extended.
- **Scoreboard.** busy[COUNT:0], one bit per physical entry.
  - rsv_en sets busy[p(rsv_addr)].
  - Any write that lands on an entry (general or SP port) clears its bit.
  - Reserve and write to the same entry in one cycle: the bit stays set, because the new reservation is for a later write.
  - Reserving an already-busy entry leaves it busy (no counting).
- **rd_busy[i]** = busy[p(rd_addr[i])] & ~(a write to that entry this cycle). A write landing this cycle resolves the hazard through the bypass.
- **Reset.** All entries, the supervisor SP and all busy bits go to 0. rd_data, sp_data_o, rd_busy and busy_any therefore read 0 in the first cycle after reset, with no writes or reserves active. Reset overrides any same-cycle write or reserve.

## Timing
- Reads are combinational from addresses, storage and same-cycle write inputs: zero-cycle latency with full bypass.
- Writes become visible in storage one clock after the strobe.
- Busy bits update one clock after rsv_en or the write.
- Minimum reserve-to-writeback distance is 1 cycle. Reserve in cycle N with write in cycle N+1 clears at N+2.
- A supervisor toggle takes effect in the same cycle for every port. A reservation made in one mode stays on that physical entry.
- No handshakes; the caller guarantees at most one write per port per cycle.

## Structure
- Package bexkat1_pkg holds:
  - the size_t enum (SZ_WORD0=0, SZ_BYTE=1, SZ_HALF=2, SZ_WORD=3)
  - the ext() function
  - the phys_addr() helper
- Sub-module regfile_scoreboard owns:
  - the busy vector
  - set/clear priority
  - the rd_busy and busy_any logic

  It takes physical indices only. The top level does banking, storage and bypass.

## Test plan
- **Reset and basic write.** Reset, then check every rd_data, sp_data_o and busy_any are 0. Then wr_en addr 3 data 0x12345680 size 1 signed 1 → same cycle rd_data (addr 3) = 0xFFFFFF80; next cycle storage holds 0xFFFFFF80.
- **SP banking.** User mode sp_en 0x1000 word, then supervisor sp_en 0x2000 → supervisor read of 15 = 0x2000, user read of 15 = 0x1000.
- **Write collision.** Same cycle, user mode, wr_en addr 15 data 0xAAAA plus sp_en data 0xBBBB word → all reads of 15 = 0xBBBB in that cycle and after.
- **Scoreboard basic.** rsv_en addr 5 → next cycle rd_busy set on port reading 5. In the writeback cycle rd_busy = 0 and rd_data = written value; after that busy_any = 0.
- **Reserve and write same entry.** rsv_en and wr_en both on addr 7 in one cycle → busy[7] remains 1; a later write clears it.
- **Reset mid-operation.** rsv_en on 2 and 9, then rst_i asserted together with wr_en 9 → all busy bits clear and entry 9 = 0.
